// File: rtl/drv_ad56x3_pkg.sv
// -----------------------------------------------------------------------------
// drv_ad56x3_pkg
// Shared definitions for the AD56x3 sample scheduler: playback FSM state
// encoding, Avalon-MM register addresses, CTRL/STATUS bit positions and the
// minimum usable tick period together with its clamp helper.
// No ports (package).
// -----------------------------------------------------------------------------
package drv_ad56x3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_PERIOD = 3'd1;
    localparam logic [2:0] ADR_LENGTH = 3'd2;
    localparam logic [2:0] ADR_WRPTR  = 3'd3;
    localparam logic [2:0] ADR_DATA0  = 3'd4;
    localparam logic [2:0] ADR_DATA1  = 3'd5;
    localparam logic [2:0] ADR_STATUS = 3'd6;
    localparam logic [2:0] ADR_RDIDX  = 3'd7;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_LOOP = 1;
    localparam int CTRL_CLR  = 2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_URUN_LSB = 8;

    localparam logic [15:0] MIN_PERIOD = 16'd2;

    // Periods shorter than the WAIT->FETCH->PRESENT pipeline cannot be met.
    function automatic logic [15:0] clamp_period(input logic [15:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

endpackage

// File: rtl/drv_ad56x3_sched_if.sv
// -----------------------------------------------------------------------------
// drv_ad56x3_sched_if
// Signal bundle for the scheduler: Avalon-MM register port, the two Avalon-ST
// sample sources and the completion interrupt.
//   master modport : host / sink side (drives address, strobes, ready)
//   slave  modport : scheduler side (drives read data, valids, data, irq)
// -----------------------------------------------------------------------------
interface drv_ad56x3_sched_if #(
    parameter int DATA_WIDTH = 14
);
    logic [2:0]            avsAdr;
    logic                  avsWr;
    logic [15:0]           avsWrData;
    logic                  avsRd;
    logic [15:0]           avsRdData;
    logic                  srcValid0;
    logic [DATA_WIDTH-1:0] srcData0;
    logic                  srcRdy0;
    logic                  srcValid1;
    logic [DATA_WIDTH-1:0] srcData1;
    logic                  srcRdy1;
    logic                  irqDone;

    modport master (
        output avsAdr, avsWr, avsWrData, avsRd, srcRdy0, srcRdy1,
        input  avsRdData, srcValid0, srcData0, srcValid1, srcData1, irqDone
    );

    modport slave (
        input  avsAdr, avsWr, avsWrData, avsRd, srcRdy0, srcRdy1,
        output avsRdData, srcValid0, srcData0, srcValid1, srcData1, irqDone
    );
endinterface

// File: rtl/drv_ad56x3_sched_ram.sv
// -----------------------------------------------------------------------------
// drv_ad56x3_sched_ram
// Simple dual-port sample-pair RAM, DEPTH x WIDTH, registered read.
//   clk, reset          : clock, synchronous active-low reset (read reg only)
//   wr_en_i/addr/data   : write port
//   rd_en_i/rd_addr_i   : read request, data on rd_data_o one cycle later
// A same-cycle write to the address being read returns the old contents.
// -----------------------------------------------------------------------------
module drv_ad56x3_sched_ram #(
    parameter int WIDTH  = 28,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // Storage array, never reset so loaded waveforms survive a reset
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; reset clears only the output register
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;
endmodule

// File: rtl/drv_ad56x3_sched.sv
// -----------------------------------------------------------------------------
// drv_ad56x3_sched
// Periodic two-channel sample scheduler for an AD56x3 DAC driver. Sample pairs
// are loaded into a RAM through an Avalon-MM register file and replayed at a
// programmable period on two Avalon-ST sources.
//   clk, reset               : clock, synchronous active-low reset
//   avsAdr/avsWr/avsWrData   : register writes
//   avsRd/avsRdData          : register reads, latency 1
//   srcValid0/srcData0/srcRdy0, srcValid1/srcData1/srcRdy1 : sample sources
//   irqDone                  : one-cycle pulse when a one-shot run ends
// -----------------------------------------------------------------------------
module drv_ad56x3_sched
    import drv_ad56x3_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            avsAdr,
    input  logic                  avsWr,
    input  logic [15:0]           avsWrData,
    input  logic                  avsRd,
    output logic [15:0]           avsRdData,
    output logic                  srcValid0,
    output logic [DATA_WIDTH-1:0] srcData0,
    input  logic                  srcRdy0,
    output logic                  srcValid1,
    output logic [DATA_WIDTH-1:0] srcData1,
    input  logic                  srcRdy1,
    output logic                  irqDone
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e                state_q, state_d;
    logic [15:0]           period_q, cnt_q, cnt_d, rdata_q, rd_mux_s;
    logic [AW-1:0]         length_q, wrptr_q, idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data0_q;
    logic [7:0]            urun_q, urun_d;
    logic                  done_q, done_d, run_q, run_d, loop_q, loop_d;
    logic                  valid0_q, valid0_d, valid1_q, valid1_d, irq_q, irq_d;
    logic                  ctrl_wr_s, busy_s, tick_s, start_s, stop_s, clr_s;
    logic                  pair_done_s, fetch_s, done_set_s;
    logic [2*DATA_WIDTH-1:0] ram_rd_s;

    assign ctrl_wr_s   = avsWr && (avsAdr == ADR_CTRL);
    assign clr_s       = ctrl_wr_s && avsWrData[CTRL_CLR];
    assign busy_s      = (state_q == ST_WAIT) || (state_q == ST_FETCH) || (state_q == ST_PRESENT);
    assign tick_s      = busy_s && (cnt_q == 16'd0);
    assign start_s     = ctrl_wr_s && avsWrData[CTRL_RUN] && !busy_s;
    // A stop request is either an earlier run=0 write or one arriving now.
    assign stop_s      = !run_q || (ctrl_wr_s && !avsWrData[CTRL_RUN]);
    assign pair_done_s = (state_q == ST_PRESENT) && (!valid0_q || srcRdy0) && (!valid1_q || srcRdy1);

    drv_ad56x3_sched_ram #(
        .WIDTH  (2 * DATA_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (avsWr && (avsAdr == ADR_DATA1)),
        .wr_addr_i (wrptr_q),
        .wr_data_i ({avsWrData[DATA_WIDTH-1:0], data0_q}),
        .rd_en_i   (fetch_s),
        .rd_addr_i (idx_q),
        .rd_data_o (ram_rd_s)
    );

    // Playback FSM next state, index and completion pulse
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fetch_s    = 1'b0;
        irq_d      = 1'b0;
        done_set_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    state_d = ST_WAIT;
                    idx_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT: begin
                if (stop_s) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FETCH: begin
                fetch_s = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                // A tick landing on the completion cycle is on time: go
                // straight to FETCH instead of losing it in WAIT.
                if (!pair_done_s) begin
                    state_d = ST_PRESENT;
                end else if (stop_s) begin
                    state_d = ST_IDLE;
                end else if (idx_q != length_q) begin
                    idx_d   = idx_q + AW'(1);
                    state_d = tick_s ? ST_FETCH : ST_WAIT;
                end else if (loop_q) begin
                    idx_d   = '0;
                    state_d = tick_s ? ST_FETCH : ST_WAIT;
                end else begin
                    state_d    = ST_DONE;
                    irq_d      = 1'b1;
                    done_set_s = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next state for the period timer, status flags, run/loop and valids
    always_comb begin
        if (start_s) begin
            cnt_d = clamp_period(period_q);
        end else if (tick_s) begin
            cnt_d = clamp_period(period_q);
        end else if (busy_s) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (clr_s) begin
            urun_d = 8'd0;
        end else if (tick_s && (state_q == ST_PRESENT) && !pair_done_s && (urun_q != 8'hFF)) begin
            urun_d = urun_q + 8'd1;
        end else begin
            urun_d = urun_q;
        end

        if (clr_s || start_s) begin
            done_d = 1'b0;
        end else if (done_set_s) begin
            done_d = 1'b1;
        end else begin
            done_d = done_q;
        end

        if (start_s) begin
            run_d = 1'b1;
        end else if (ctrl_wr_s && !avsWrData[CTRL_RUN]) begin
            run_d = 1'b0;
        end else if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
            run_d = 1'b0;
        end else begin
            run_d = run_q;
        end

        if (ctrl_wr_s) begin
            loop_d = avsWrData[CTRL_LOOP];
        end else begin
            loop_d = loop_q;
        end

        // Each channel drops on its own once its sink has taken the sample.
        if (fetch_s) begin
            valid0_d = 1'b1;
            valid1_d = 1'b1;
        end else if (state_q == ST_PRESENT) begin
            valid0_d = valid0_q && !srcRdy0;
            valid1_d = valid1_q && !srcRdy1;
        end else begin
            valid0_d = 1'b0;
            valid1_d = 1'b0;
        end
    end

    // Register read multiplexer; write-only and unused bits read as zero
    always_comb begin
        rd_mux_s = 16'd0;
        case (avsAdr)
            ADR_PERIOD: rd_mux_s = period_q;
            ADR_LENGTH: rd_mux_s[AW-1:0] = length_q;
            ADR_WRPTR:  rd_mux_s[AW-1:0] = wrptr_q;
            ADR_STATUS: begin
                rd_mux_s[STAT_BUSY]         = busy_s;
                rd_mux_s[STAT_DONE]         = done_q;
                rd_mux_s[STAT_URUN_LSB +: 8] = urun_q;
            end
            ADR_RDIDX:  rd_mux_s[AW-1:0] = idx_q;
            default:    rd_mux_s = 16'd0;
        endcase
    end

    // Playback state, status and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= 16'd0;
            urun_q   <= 8'd0;
            done_q   <= 1'b0;
            run_q    <= 1'b0;
            loop_q   <= 1'b0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            urun_q   <= urun_d;
            done_q   <= done_d;
            run_q    <= run_d;
            loop_q   <= loop_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            irq_q    <= irq_d;
            rdata_q  <= avsRd ? rd_mux_s : 16'd0;
        end
    end

    // Host-writable configuration and the RAM load pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            period_q <= 16'd0;
            length_q <= '0;
            wrptr_q  <= '0;
            data0_q  <= '0;
        end else if (avsWr) begin
            case (avsAdr)
                ADR_PERIOD: period_q <= avsWrData;
                ADR_LENGTH: length_q <= avsWrData[AW-1:0];
                ADR_WRPTR:  wrptr_q  <= avsWrData[AW-1:0];
                ADR_DATA0:  data0_q  <= avsWrData[DATA_WIDTH-1:0];
                ADR_DATA1:  wrptr_q  <= wrptr_q + AW'(1);
                default:    ;
            endcase
        end
    end

    assign srcValid0 = valid0_q;
    assign srcValid1 = valid1_q;
    assign srcData0  = ram_rd_s[DATA_WIDTH-1:0];
    assign srcData1  = ram_rd_s[2*DATA_WIDTH-1:DATA_WIDTH];
    assign irqDone   = irq_q;
    assign avsRdData = rdata_q;
endmodule

// File: tb/tb_drv_ad56x3_sched.sv
// -----------------------------------------------------------------------------
// tb_drv_ad56x3_sched
// Directed bench for drv_ad56x3_sched. Cycle 0 is the cycle in which the CTRL
// run write is presented; cyc counts clock edges from there. Inputs change 1
// time unit after the rising edge, outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_drv_ad56x3_sched;
    import drv_ad56x3_pkg::*;

    localparam int DW = 14;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   irq_cnt = 0;

    drv_ad56x3_sched_if #(.DATA_WIDTH(DW)) bus();

    drv_ad56x3_sched #(.DATA_WIDTH(DW), .DEPTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .avsAdr    (bus.avsAdr),
        .avsWr     (bus.avsWr),
        .avsWrData (bus.avsWrData),
        .avsRd     (bus.avsRd),
        .avsRdData (bus.avsRdData),
        .srcValid0 (bus.srcValid0),
        .srcData0  (bus.srcData0),
        .srcRdy0   (bus.srcRdy0),
        .srcValid1 (bus.srcValid1),
        .srcData1  (bus.srcData1),
        .srcRdy1   (bus.srcRdy1),
        .irqDone   (bus.irqDone)
    );

    always #5 clk = ~clk;

    // Count cycles with irqDone high
    always @(posedge clk) begin
        if (bus.irqDone === 1'b1) irq_cnt <= irq_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.avsWr = 1'b0;
        bus.avsRd = 1'b0;
        cyc++;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.avsAdr = a; bus.avsWr = 1'b1; bus.avsWrData = d;
        step();
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        bus.avsAdr = a; bus.avsRd = 1'b1;
        step();
        d = bus.avsRdData;
    endtask

    task automatic start(input logic [15:0] ctrl);
        bus.avsAdr = ADR_CTRL; bus.avsWr = 1'b1; bus.avsWrData = ctrl;
        cyc = 0;
        step();
    endtask

    initial begin
        logic [15:0] r;
        int k;
        int irq_base;

        reset = 1'b0;
        bus.avsAdr = 3'd0; bus.avsWr = 1'b0; bus.avsWrData = 16'd0; bus.avsRd = 1'b0;
        bus.srcRdy0 = 1'b1; bus.srcRdy1 = 1'b1;
        repeat (3) step();
        check_val("rst_valid0", 32'(bus.srcValid0), 32'd0);
        check_val("rst_valid1", 32'(bus.srcValid1), 32'd0);
        check_val("rst_data0",  32'(bus.srcData0),  32'd0);
        check_val("rst_irq",    32'(bus.irqDone),   32'd0);
        check_val("rst_rdata",  32'(bus.avsRdData), 32'd0);
        reset = 1'b1;
        step();
        rd(ADR_STATUS, r); check_val("rst_status", 32'(r), 32'd0);
        rd(ADR_PERIOD, r); check_val("rst_period", 32'(r), 32'd0);

        // Load pairs (0x100,0x200) .. (0x400,0x800)
        wr(ADR_WRPTR, 16'd0);
        for (int i = 0; i < 4; i++) begin
            wr(ADR_DATA0, 16'(256 * (i + 1)));
            wr(ADR_DATA1, 16'(512 * (i + 1)));
        end
        rd(ADR_WRPTR, r); check_val("wrptr_after_load", 32'(r), 32'd4);
        wr(ADR_LENGTH, 16'd3);
        wr(ADR_PERIOD, 16'd9);
        rd(ADR_LENGTH, r); check_val("length_rb", 32'(r), 32'd3);
        rd(ADR_PERIOD, r); check_val("period_rb", 32'(r), 32'd9);
        rd(ADR_CTRL, r);   check_val("ctrl_reads_zero", 32'(r), 32'd0);

        // One-shot run: pairs at 12, 22, 32, 42, irq at 43
        irq_base = irq_cnt;
        start(16'h0001);
        while (cyc < 46) begin
            if ((cyc % 10 == 2) && cyc >= 12 && cyc <= 42) begin
                k = (cyc - 12) / 10;
                check_val("os_valid0", 32'(bus.srcValid0), 32'd1);
                check_val("os_valid1", 32'(bus.srcValid1), 32'd1);
                check_val("os_data0", 32'(bus.srcData0), 32'(256 * (k + 1)));
                check_val("os_data1", 32'(bus.srcData1), 32'(512 * (k + 1)));
            end
            if ((cyc % 10 == 1) && cyc >= 11 && cyc <= 41)
                check_val("os_valid_early", 32'(bus.srcValid0), 32'd0);
            if (cyc == 43) check_val("os_irq_hi", 32'(bus.irqDone), 32'd1);
            if (cyc == 44) check_val("os_irq_lo", 32'(bus.irqDone), 32'd0);
            step();
        end
        check_val("os_irq_count", 32'(irq_cnt - irq_base), 32'd1);
        rd(ADR_STATUS, r); check_val("os_status", 32'(r), 32'h0002);
        rd(ADR_RDIDX, r);  check_val("os_rdidx", 32'(r), 32'd3);

        // Looping run: 10 pairs wrapping 3->0, then stop during FETCH
        irq_base = irq_cnt;
        start(16'h0003);
        while (cyc < 106) begin
            if ((cyc % 10 == 2) && cyc >= 12 && cyc <= 102) begin
                k = ((cyc - 12) / 10) % 4;
                check_val("lp_valid0", 32'(bus.srcValid0), 32'd1);
                check_val("lp_data0", 32'(bus.srcData0), 32'(256 * (k + 1)));
                check_val("lp_data1", 32'(bus.srcData1), 32'(512 * (k + 1)));
            end
            if (cyc == 50) begin bus.avsAdr = ADR_STATUS; bus.avsRd = 1'b1; end
            if (cyc == 51) check_val("lp_busy", 32'(bus.avsRdData), 32'h0001);
            if (cyc == 101) begin bus.avsAdr = ADR_CTRL; bus.avsWr = 1'b1; bus.avsWrData = 16'h0002; end
            if (cyc == 103) begin bus.avsAdr = ADR_STATUS; bus.avsRd = 1'b1; end
            if (cyc == 104) check_val("lp_stop_idle", 32'(bus.avsRdData), 32'h0000);
            step();
        end
        check_val("lp_no_irq", 32'(irq_cnt - irq_base), 32'd0);

        // Underrun: channel 1 sink stalls for cycles 12..36
        wr(ADR_CTRL, 16'h0004);
        bus.srcRdy1 = 1'b0;
        start(16'h0001);
        while (cyc < 46) begin
            if (cyc == 12) begin
                check_val("ur_v0_start", 32'(bus.srcValid0), 32'd1);
                check_val("ur_v1_start", 32'(bus.srcValid1), 32'd1);
            end
            if (cyc == 13) begin
                check_val("ur_v0_drop", 32'(bus.srcValid0), 32'd0);
                check_val("ur_v1_held", 32'(bus.srcValid1), 32'd1);
            end
            if (cyc == 36) begin
                check_val("ur_v1_still", 32'(bus.srcValid1), 32'd1);
                check_val("ur_data1_stable", 32'(bus.srcData1), 32'h200);
            end
            if (cyc == 37) bus.srcRdy1 = 1'b1;
            if (cyc == 38) check_val("ur_v1_drop", 32'(bus.srcValid1), 32'd0);
            if (cyc == 42) begin
                check_val("ur_next_valid", 32'(bus.srcValid0), 32'd1);
                check_val("ur_no_skip", 32'(bus.srcData0), 32'h200);
            end
            if (cyc == 43) begin bus.avsAdr = ADR_STATUS; bus.avsRd = 1'b1; end
            if (cyc == 44) check_val("ur_status", 32'(bus.avsRdData), 32'h0201);
            if (cyc == 45) begin bus.avsAdr = ADR_CTRL; bus.avsWr = 1'b1; bus.avsWrData = 16'h0000; end
            step();
        end

        // Saturation: clamped period 2, both sinks stalled
        wr(ADR_PERIOD, 16'd0);
        bus.srcRdy0 = 1'b0; bus.srcRdy1 = 1'b0;
        start(16'h0001);
        while (cyc < 950) step();
        rd(ADR_STATUS, r); check_val("sat_status", 32'(r), 32'hFF01);
        wr(ADR_CTRL, 16'h0004);
        rd(ADR_STATUS, r); check_val("clr_status", 32'(r), 32'h0001);

        // Reset while presenting drops valids at once
        check_val("pre_rst_valid", 32'(bus.srcValid0), 32'd1);
        reset = 1'b0;
        step();
        check_val("mid_rst_v0", 32'(bus.srcValid0), 32'd0);
        check_val("mid_rst_v1", 32'(bus.srcValid1), 32'd0);
        check_val("mid_rst_d0", 32'(bus.srcData0), 32'd0);
        reset = 1'b1;
        step();
        rd(ADR_STATUS, r); check_val("post_rst_status", 32'(r), 32'd0);

        // PERIOD=0 after reset: spacing 3, RAM kept its contents
        bus.srcRdy0 = 1'b1; bus.srcRdy1 = 1'b1;
        start(16'h0003);
        while (cyc < 12) begin
            if (cyc == 5 || cyc == 8 || cyc == 11) begin
                check_val("clamp_valid", 32'(bus.srcValid0), 32'd1);
                check_val("clamp_ram_kept", 32'(bus.srcData0), 32'h100);
            end
            if (cyc == 6 || cyc == 7 || cyc == 4)
                check_val("clamp_gap", 32'(bus.srcValid0), 32'd0);
            step();
        end
        wr(ADR_CTRL, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
